warp_scheduler: RTL and testbench
=================================

Name: warp_scheduler

Overview:
- Per-warp state tracker and round-robin warp selector that feeds the Issue stage.
- Grants one ready warp per cycle as the selected warp.
- Consumes the issued sync/exit feedback to park warps at barriers and retire exited warps.
- Releases a barrier when every live warp has reached it, and flags kernel completion.

Parameters:
- NUM_WARP, 8, number of hardware warps.
- NUM_WARP_LOG, 3, log2(NUM_WARP); width of warp IDs.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start_i  in  1  launch pulse; honoured only when not busy_o.
- warpEnable_i  in  NUM_WARP  warps taking part in the launch; sampled with start_i.
- warpReady_i  in  NUM_WARP  per-warp instruction-buffer valid and scoreboard clear.
- stall_i  in  1  downstream backpressure; suppresses new grants.
- issuedValid_i  in  1  Issue stage presented a valid packet this cycle.
- issuedWarp_i  in  NUM_WARP_LOG  warp ID of the issued packet.
- issuedSync_i  in  1  issued packet is a barrier sync.
- issuedExit_i  in  1  issued packet is an exit.
- selectedWarp_o  out  NUM_WARP_LOG  granted warp ID (registered).
- selectedValid_o  out  1  grant valid (registered).
- barrierRelease_o  out  1  one-cycle pulse when a barrier is released.
- busy_o  out  1  a launched kernel has at least one warp not DONE.
- allDone_o  out  1  one-cycle pulse when the last live warp reaches DONE.

Behaviour:
- Per-warp 2-bit state: IDLE=0, RUN=1, SYNC=2, DONE=3.
- Reset (async, any time including mid-kernel):
  - all warps IDLE; round-robin pointer = NUM_WARP-1 (warp 0 has first priority);
  - all outputs 0.
- Launch: start_i && !busy_o → next edge, warps with enable=1 go RUN, others go DONE; busy_o=1.
  - start_i while busy_o is ignored.
  - start_i with warpEnable_i=0: all warps DONE, busy_o stays 0, no allDone_o pulse.
- Eligibility of warp w: state==RUN && warpReady_i[w] && !(selectedValid_o && selectedWarp_o==w).
  - The last grant is locked out for one cycle, because its sync/exit feedback only arrives in the cycle it is presented.
- Grant: computed combinationally, registered on the edge.
  - Search order: pointer+1, pointer+2, … modulo NUM_WARP; first eligible warp wins.
  - On grant: selectedValid_o=1, selectedWarp_o=w, pointer=w.
  - With stall_i=1 or no eligible warp: selectedValid_o=0, selectedWarp_o holds, pointer holds.
  - Latency: warpReady_i → selectedValid_o is 1 cycle.
- Feedback: on issuedValid_i, warp issuedWarp_i in RUN takes the following transition at the next edge:
  - exit=1 → DONE (exit wins if sync is also set);
  - sync=1 → SYNC;
  - otherwise unchanged.
  - Feedback for a warp not in RUN is ignored.
- Barrier: evaluated on registered state only.
  - If no warp is in RUN, ≥1 warp is in SYNC, and no feedback is being applied this cycle: all SYNC warps → RUN at the next edge, and barrierRelease_o pulses that cycle.
  - DONE warps do not participate in the barrier.
- Completion: when feedback moves the last non-DONE warp to DONE, then at that edge busy_o→0 and allDone_o pulses for 1 cycle.
  - No barrier is released on that edge.
- Simultaneous grant and feedback for different warps are both applied on the same edge.

Test Plan:
- Round-robin: reset, start_i with warpEnable_i=8'hFF, all warpReady_i=1, no feedback → grants 0,1,2,…,7,0 on consecutive cycles; the same warp is never granted twice in a row.
- Lockout/stall: enable=8'h01, ready=1 → grants alternate valid/invalid (W0, bubble, W0, …); stall_i held high for 3 cycles → selectedValid_o=0 for those 3 cycles, and on stall release the grant resumes from pointer+1.
- Barrier: enable=8'h0F; issue sync for W0, W1, W2 → no release; sync for W3 → barrierRelease_o pulses once and W0..W3 are granted again in order 0,1,2,3.
- Exit with barrier: enable=8'h03; W0 sync, then W1 exit → barrier released, W0 back to RUN; W0 exit → allDone_o pulse, busy_o=0, no further grants.
- Sync+exit together on W2 → W2 goes DONE, never enters SYNC; feedback for a DONE warp leaves state unchanged.
- Async reset asserted mid-kernel (W1 in SYNC, selectedValid_o=1) → outputs drop to 0 without a clock edge; after deassert, start_i with 8'h02 grants W1 first.

Source files
------------

// File: rtl/warp_scheduler.sv
// Per-warp IDLE/RUN/SYNC/DONE tracker with a round-robin grant to the Issue stage.
// Parks warps at barriers, releases them when no warp is left running, and retires exited warps.
module warp_scheduler #(
  parameter int NUM_WARP     = 8,
  parameter int NUM_WARP_LOG = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start_i,
  input  logic [NUM_WARP-1:0]     warpEnable_i,
  input  logic [NUM_WARP-1:0]     warpReady_i,
  input  logic                    stall_i,
  input  logic                    issuedValid_i,
  input  logic [NUM_WARP_LOG-1:0] issuedWarp_i,
  input  logic                    issuedSync_i,
  input  logic                    issuedExit_i,
  output logic [NUM_WARP_LOG-1:0] selectedWarp_o,
  output logic                    selectedValid_o,
  output logic                    barrierRelease_o,
  output logic                    busy_o,
  output logic                    allDone_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    SYNC = 2'd2,
    DONE = 2'd3
  } warpState_t;

  warpState_t              warpState     [NUM_WARP];
  warpState_t              warpStateNext [NUM_WARP];
  logic [NUM_WARP_LOG-1:0] rrPtr;

  logic [NUM_WARP-1:0]     eligible;
  logic                    grantFound;
  logic [NUM_WARP_LOG-1:0] grantWarp;
  logic [NUM_WARP_LOG-1:0] searchIdx;
  logic                    launch;
  logic                    fbApply;
  logic                    anyRun;
  logic                    anySync;
  logic                    othersDone;
  logic                    releaseNow;
  logic                    lastExit;

  // The previous grant is masked because its sync/exit feedback has not arrived yet.
  always_comb begin
    eligible   = '0;
    grantFound = 1'b0;
    grantWarp  = rrPtr;
    searchIdx  = rrPtr;
    for (int w = 0; w < NUM_WARP; w++) begin
      eligible[w] = (warpState[w] == RUN) && warpReady_i[w] &&
                    !(selectedValid_o && (selectedWarp_o == NUM_WARP_LOG'(w)));
    end
    for (int k = 1; k <= NUM_WARP; k++) begin
      searchIdx = rrPtr + NUM_WARP_LOG'(k);
      if (!grantFound && eligible[searchIdx]) begin
        grantFound = 1'b1;
        grantWarp  = searchIdx;
      end
    end
  end

  always_comb begin
    launch     = start_i && !busy_o;
    fbApply    = issuedValid_i && (warpState[issuedWarp_i] == RUN);
    anyRun     = 1'b0;
    anySync    = 1'b0;
    othersDone = 1'b1;
    for (int w = 0; w < NUM_WARP; w++) begin
      if (warpState[w] == RUN)  anyRun  = 1'b1;
      if (warpState[w] == SYNC) anySync = 1'b1;
      if ((NUM_WARP_LOG'(w) != issuedWarp_i) && (warpState[w] != DONE)) othersDone = 1'b0;
    end
    releaseNow = !anyRun && anySync && !fbApply;
    lastExit   = busy_o && fbApply && issuedExit_i && othersDone;
  end

  assign barrierRelease_o = releaseNow;

  always_comb begin
    for (int w = 0; w < NUM_WARP; w++) begin
      warpStateNext[w] = warpState[w];
      if (launch) begin
        warpStateNext[w] = warpEnable_i[w] ? RUN : DONE;
      end else if (fbApply && (NUM_WARP_LOG'(w) == issuedWarp_i)) begin
        if (issuedExit_i)      warpStateNext[w] = DONE;
        else if (issuedSync_i) warpStateNext[w] = SYNC;
      end else if (releaseNow && (warpState[w] == SYNC)) begin
        warpStateNext[w] = RUN;
      end
    end
  end

  // State register and registered grant/status outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int w = 0; w < NUM_WARP; w++) warpState[w] <= IDLE;
      rrPtr           <= NUM_WARP_LOG'(NUM_WARP - 1);
      selectedWarp_o  <= '0;
      selectedValid_o <= 1'b0;
      busy_o          <= 1'b0;
      allDone_o       <= 1'b0;
    end else begin
      for (int w = 0; w < NUM_WARP; w++) warpState[w] <= warpStateNext[w];
      if (!stall_i && grantFound) begin
        selectedValid_o <= 1'b1;
        selectedWarp_o  <= grantWarp;
        rrPtr           <= grantWarp;
      end else begin
        selectedValid_o <= 1'b0;
      end
      if (launch)        busy_o <= |warpEnable_i;
      else if (lastExit) busy_o <= 1'b0;
      allDone_o <= lastExit;
    end
  end

endmodule

// File: tb/tb_warp_scheduler.sv
// Randomized and directed bench for warp_scheduler against a cycle-level reference model
// built from the warp-state rules (integer arrays, plain loops).
module tb_warp_scheduler;

  localparam int NW = 8;
  localparam int ST_IDLE = 0, ST_RUN = 1, ST_SYNC = 2, ST_DONE = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       startIn;
  logic [7:0] warpEnable;
  logic [7:0] warpReady;
  logic       stall;
  logic       issuedValid;
  logic [2:0] issuedWarp;
  logic       issuedSync;
  logic       issuedExit;
  logic [2:0] selectedWarp;
  logic       selectedValid;
  logic       barrierRelease;
  logic       busy;
  logic       allDone;

  int checks = 0;
  int errors = 0;

  // reference model
  int mState [NW];
  int mPtr, mSelW;
  int mSelV, mBusy, mAllDone;

  warp_scheduler #(.NUM_WARP(8), .NUM_WARP_LOG(3)) dut (
    .clk              (clk),
    .reset            (reset),
    .start_i          (startIn),
    .warpEnable_i     (warpEnable),
    .warpReady_i      (warpReady),
    .stall_i          (stall),
    .issuedValid_i    (issuedValid),
    .issuedWarp_i     (issuedWarp),
    .issuedSync_i     (issuedSync),
    .issuedExit_i     (issuedExit),
    .selectedWarp_o   (selectedWarp),
    .selectedValid_o  (selectedValid),
    .barrierRelease_o (barrierRelease),
    .busy_o           (busy),
    .allDone_o        (allDone)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    for (int w = 0; w < NW; w++) mState[w] = ST_IDLE;
    mPtr = NW - 1; mSelW = 0; mSelV = 0; mBusy = 0; mAllDone = 0;
  endtask

  // One clock: entered at posedge+1 with inputs already driven, leaves at next posedge+1.
  task automatic step();
    int nState [NW];
    int runCnt, syncCnt, notDone, fbHit, rel, found, gw, w, nBusy, nDone;
    for (int i = 0; i < NW; i++) nState[i] = mState[i];
    runCnt = 0; syncCnt = 0;
    for (int i = 0; i < NW; i++) begin
      if (mState[i] == ST_RUN)  runCnt++;
      if (mState[i] == ST_SYNC) syncCnt++;
    end
    fbHit = (issuedValid && mState[issuedWarp] == ST_RUN) ? 1 : 0;
    rel   = (runCnt == 0 && syncCnt > 0 && !fbHit) ? 1 : 0;
    found = 0; gw = 0;
    if (!stall) begin
      for (int k = 1; k <= NW; k++) begin
        w = (mPtr + k) % NW;
        if (!found && mState[w] == ST_RUN && warpReady[w] && !(mSelV && mSelW == w)) begin
          found = 1; gw = w;
        end
      end
    end
    nBusy = mBusy; nDone = 0;
    if (startIn && !mBusy) begin
      for (int i = 0; i < NW; i++) nState[i] = warpEnable[i] ? ST_RUN : ST_DONE;
      nBusy = (warpEnable != 0) ? 1 : 0;
    end else begin
      if (fbHit) begin
        if (issuedExit)      nState[issuedWarp] = ST_DONE;
        else if (issuedSync) nState[issuedWarp] = ST_SYNC;
      end
      if (rel) for (int i = 0; i < NW; i++) if (mState[i] == ST_SYNC) nState[i] = ST_RUN;
      notDone = 0;
      for (int i = 0; i < NW; i++) if (nState[i] != ST_DONE) notDone++;
      if (mBusy && fbHit && issuedExit && notDone == 0) begin
        nDone = 1; nBusy = 0;
      end
    end
    #1;
    checkVal("barrierRelease", barrierRelease, rel);
    @(posedge clk); #1;
    for (int i = 0; i < NW; i++) mState[i] = nState[i];
    if (found) begin mSelV = 1; mSelW = gw; mPtr = gw; end
    else mSelV = 0;
    mBusy = nBusy; mAllDone = nDone;
    checkVal("selectedValid", selectedValid, mSelV);
    checkVal("selectedWarp", selectedWarp, mSelW);
    checkVal("busy", busy, mBusy);
    checkVal("allDone", allDone, mAllDone);
  endtask

  task automatic drive(input logic st, input logic [7:0] en, input logic [7:0] rdy,
                       input logic stl, input logic iv, input logic [2:0] iw,
                       input logic is, input logic ie);
    startIn = st; warpEnable = en; warpReady = rdy; stall = stl;
    issuedValid = iv; issuedWarp = iw; issuedSync = is; issuedExit = ie;
    step();
  endtask

  task automatic idle(input logic [7:0] rdy, input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00, rdy, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
  endtask

  // Asserted mid-cycle; outputs must clear without waiting for an edge.
  task automatic asyncReset();
    reset = 1'b1;
    #1;
    checkVal("rst selectedValid", selectedValid, 0);
    checkVal("rst selectedWarp", selectedWarp, 0);
    checkVal("rst busy", busy, 0);
    checkVal("rst allDone", allDone, 0);
    checkVal("rst barrierRelease", barrierRelease, 0);
    modelReset();
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    int guard;
    reset = 1'b1; startIn = 0; warpEnable = 0; warpReady = 0; stall = 0;
    issuedValid = 0; issuedWarp = 0; issuedSync = 0; issuedExit = 0;
    modelReset();
    @(posedge clk); #1;
    asyncReset();

    // Round-robin over all eight warps
    drive(1'b1, 8'hFF, 8'hFF, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    idle(8'hFF, 10);
    drive(1'b1, 8'h01, 8'hFF, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0); // ignored while busy
    asyncReset();

    // Single warp lockout and stall
    drive(1'b1, 8'h01, 8'hFF, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    idle(8'hFF, 5);
    for (int i = 0; i < 3; i++) drive(1'b0, 8'h00, 8'hFF, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
    idle(8'hFF, 4);
    asyncReset();

    // Four-warp barrier
    drive(1'b1, 8'h0F, 8'hFF, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    idle(8'hFF, 2);
    for (int w = 0; w < 4; w++) drive(1'b0, 8'h00, 8'hFF, 1'b0, 1'b1, 3'(w), 1'b1, 1'b0);
    idle(8'hFF, 8);
    asyncReset();

    // Exit completes a barrier, then the last exit finishes the kernel
    drive(1'b1, 8'h03, 8'hFF, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    idle(8'hFF, 2);
    drive(1'b0, 8'h00, 8'hFF, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0);
    drive(1'b0, 8'h00, 8'hFF, 1'b0, 1'b1, 3'd1, 1'b0, 1'b1);
    idle(8'hFF, 3);
    drive(1'b0, 8'h00, 8'hFF, 1'b0, 1'b1, 3'd0, 1'b0, 1'b1);
    checkVal("kernel done pulse", allDone, 1);
    idle(8'hFF, 4);
    checkVal("no grant after done", selectedValid, 0);

    // Sync+exit together, then feedback for a DONE warp
    drive(1'b1, 8'h07, 8'hFF, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    idle(8'hFF, 1);
    drive(1'b0, 8'h00, 8'hFF, 1'b0, 1'b1, 3'd2, 1'b1, 1'b1);
    drive(1'b0, 8'h00, 8'hFF, 1'b0, 1'b1, 3'd2, 1'b1, 1'b0);
    idle(8'hFF, 4);
    asyncReset();

    // Empty launch: no busy and no completion pulse
    drive(1'b1, 8'h00, 8'hFF, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    idle(8'hFF, 2);
    asyncReset();

    // Reset while W1 is parked and a grant is live
    drive(1'b1, 8'h03, 8'hFF, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    idle(8'hFF, 1);
    drive(1'b0, 8'h00, 8'hFF, 1'b0, 1'b1, 3'd1, 1'b1, 1'b0);
    guard = 0;
    while (!mSelV && guard < 10) begin idle(8'hFF, 1); guard++; end
    checkVal("grant live before reset", selectedValid, 1);
    asyncReset();
    drive(1'b1, 8'h02, 8'hFF, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    idle(8'hFF, 1);
    checkVal("first grant after reset valid", selectedValid, 1);
    checkVal("first grant after reset warp", selectedWarp, 1);
    asyncReset();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0, 8'($urandom), 8'($urandom),
            ($urandom_range(0, 4) == 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0, 3'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0) ? 1'b1 : 1'b0);
      if (i % 700 == 350) asyncReset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
